// File: rtl/serial_sub.sv
// Digit-serial subtractor: d = (a - b - bin) mod 2^WIDTH, DIGIT bits per cycle from the LSB, borrow kept in a register.
// Defining SERSUB_FLAGS_EN adds the eq (d == 0) and ovf (signed overflow) result flags.
module serial_sub #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bout
`ifdef SERSUB_FLAGS_EN
  ,
  output logic             eq,
  output logic             ovf
`endif
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  generate
    if (WIDTH < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
      $error("serial_sub: WIDTH must be >= 1 and a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             brw_q, brw_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             bout_q, bout_d;
  logic             rdy_q, vld_q;
  logic [DIGIT:0]   dig;
  logic [WIDTH-1:0] res_new;

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    brw_d   = brw_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    bout_d  = bout_q;

    // One DIGIT+1 bit subtraction; the MSB is the borrow into the next digit.
    dig = {1'b0, opa_q[cnt_q*DIGIT +: DIGIT]}
        - {1'b0, opb_q[cnt_q*DIGIT +: DIGIT]}
        - {{DIGIT{1'b0}}, brw_q};
    res_new = res_q;
    res_new[cnt_q*DIGIT +: DIGIT] = dig[DIGIT-1:0];

    case (state_q)
      S_IDLE: begin
        if (in_valid && rdy_q) begin
          opa_d   = a;
          opb_d   = b;
          brw_d   = bin;
          cnt_d   = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        res_d = res_new;
        brw_d = dig[DIGIT];
        if (cnt_q == LAST) begin
          bout_d  = dig[DIGIT];
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      brw_q   <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      bout_q  <= 1'b0;
      rdy_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      brw_q   <= brw_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      bout_q  <= bout_d;
      rdy_q   <= (state_d == S_IDLE);
      vld_q   <= (state_d == S_DONE);
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = vld_q;
  assign d         = res_q;
  assign bout      = bout_q;

`ifdef SERSUB_FLAGS_EN
  logic eq_q, ovf_q;

  // Flags are taken from the completed result on the final digit, so they hold with d.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eq_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else if (state_q == S_BUSY && cnt_q == LAST) begin
      eq_q  <= (res_new == '0);
      ovf_q <= (opa_q[WIDTH-1] ^ opb_q[WIDTH-1]) & (res_new[WIDTH-1] ^ opa_q[WIDTH-1]);
    end
  end

  assign eq  = eq_q;
  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub.sv
// Bench for serial_sub: WIDTH=16/DIGIT=4 main instance plus a DIGIT=16 instance, checked against an arithmetic model.
module tb_serial_sub;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, bin, bout;
  logic [15:0] a, b, d;
  logic        iv2, ir2, ov2, or2, bo2;
  logic [15:0] d2;
`ifdef SERSUB_FLAGS_EN
  logic        eq, ovf, eq2, ovf2;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_sub #(.WIDTH(16), .DIGIT(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .d(d), .bout(bout)
`ifdef SERSUB_FLAGS_EN
    , .eq(eq), .ovf(ovf)
`endif
  );

  serial_sub #(.WIDTH(16), .DIGIT(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2),
    .a(a), .b(b), .bin(bin), .out_valid(ov2), .out_ready(or2),
    .d(d2), .bout(bo2)
`ifdef SERSUB_FLAGS_EN
    , .eq(eq2), .ovf(ovf2)
`endif
  );

  function automatic logic [15:0] m_diff(input logic [15:0] x, input logic [15:0] y, input logic c);
    int r;
    r = int'(x) - int'(y) - int'(c);
    return r[15:0];
  endfunction

  function automatic logic m_bout(input logic [15:0] x, input logic [15:0] y, input logic c);
    return int'(x) < (int'(y) + int'(c));
  endfunction

  function automatic logic m_ovf(input logic [15:0] x, input logic [15:0] y, input logic c);
    int s;
    s = int'($signed(x)) - int'($signed(y)) - int'(c);
    return (s < -32768) || (s > 32767);
  endfunction

  // Drives one operation starting at a negedge; returns observations, no checking.
  task automatic do_op(input logic [15:0] ta, input logic [15:0] tbv, input logic tbin, input int hold,
                       output logic [15:0] od, output logic ob, output logic oe, output logic oo,
                       output int lat, output bit rdy_busy, output bit stable, output bit idle_rdy);
    int n;
    a = ta; b = tbv; bin = tbin; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
    lat = -1; rdy_busy = 0; stable = 1; idle_rdy = 0; n = 0;
    od = 'x; ob = 1'bx; oe = 1'b0; oo = 1'b0;
    while (n < 64 && lat < 0) begin
      if (out_valid) lat = n;
      else begin
        if (in_ready) rdy_busy = 1;
        @(negedge clk);
        n++;
      end
    end
    if (lat < 0) return;
    od = d; ob = bout;
`ifdef SERSUB_FLAGS_EN
    oe = eq; oo = ovf;
`endif
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
      @(negedge clk);
      if (d !== od || bout !== ob || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 0;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    idle_rdy = (in_ready === 1'b1 && out_valid === 1'b0);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 0; out_ready = 0; a = 0; b = 0; bin = 0; iv2 = 0; or2 = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, out_valid, d, bout} !== 19'd0) begin
      errors++; $display("FAIL reset_outputs: got rdy=%b vld=%b d=%h bout=%b, want all 0", in_ready, out_valid, d, bout);
    end
    checks++;
    if ({ir2, ov2, d2, bo2} !== 19'd0) begin
      errors++; $display("FAIL reset_outputs16: got rdy=%b vld=%b d=%h bout=%b, want all 0", ir2, ov2, d2, bo2);
    end
`ifdef SERSUB_FLAGS_EN
    checks++;
    if ({eq, ovf} !== 2'b00) begin
      errors++; $display("FAIL reset_flags: got eq=%b ovf=%b, want 0 0", eq, ovf);
    end
`endif
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_release: got rdy=%b vld=%b, want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_directed;
    logic [15:0] va[4] = '{16'h1234, 16'h0000, 16'h1000, 16'h8000};
    logic [15:0] vb[4] = '{16'h0234, 16'h0001, 16'h0FFF, 16'h0001};
    logic        vc[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [15:0] od; logic ob, oe, oo; int lat; bit rb, st, ir;
    for (int i = 0; i < 4; i++) begin
      do_op(va[i], vb[i], vc[i], 0, od, ob, oe, oo, lat, rb, st, ir);
      checks++;
      if (lat !== 4) begin
        errors++; $display("FAIL dir%0d_latency: got %0d want 4", i, lat);
      end
      checks++;
      if (od !== m_diff(va[i], vb[i], vc[i]) || ob !== m_bout(va[i], vb[i], vc[i])) begin
        errors++; $display("FAIL dir%0d_result: got d=%h bout=%b want d=%h bout=%b", i, od, ob,
                           m_diff(va[i], vb[i], vc[i]), m_bout(va[i], vb[i], vc[i]));
      end
      checks++;
      if (rb || !ir) begin
        errors++; $display("FAIL dir%0d_in_ready: got busy_ready=%b idle_ready=%b want 0 1", i, rb, ir);
      end
`ifdef SERSUB_FLAGS_EN
      checks++;
      if (oe !== (m_diff(va[i], vb[i], vc[i]) == 16'h0) || oo !== m_ovf(va[i], vb[i], vc[i])) begin
        errors++; $display("FAIL dir%0d_flags: got eq=%b ovf=%b want eq=%b ovf=%b", i, oe, oo,
                           m_diff(va[i], vb[i], vc[i]) == 16'h0, m_ovf(va[i], vb[i], vc[i]));
      end
`endif
    end
  endtask

  task automatic test_backpressure;
    logic [15:0] od; logic ob, oe, oo; int lat; bit rb, st, ir;
    do_op(16'h4321, 16'h5678, 1'b1, 5, od, ob, oe, oo, lat, rb, st, ir);
    checks++;
    if (!st) begin
      errors++; $display("FAIL bp_stable: got outputs changed during hold, want frozen");
    end
    checks++;
    if (od !== m_diff(16'h4321, 16'h5678, 1'b1) || ob !== 1'b1) begin
      errors++; $display("FAIL bp_result: got d=%h bout=%b want d=%h bout=1", od, ob, m_diff(16'h4321, 16'h5678, 1'b1));
    end
    checks++;
    if (!ir) begin
      errors++; $display("FAIL bp_idle: got in_ready=%b after release, want 1", in_ready);
    end
    // Immediately issue the next operation; it must be accepted on the following edge.
    do_op(16'h00FF, 16'h0F0F, 1'b0, 0, od, ob, oe, oo, lat, rb, st, ir);
    checks++;
    if (lat !== 4 || od !== m_diff(16'h00FF, 16'h0F0F, 1'b0)) begin
      errors++; $display("FAIL bp_next: got lat=%0d d=%h want lat=4 d=%h", lat, od, m_diff(16'h00FF, 16'h0F0F, 1'b0));
    end
  endtask

  task automatic test_reset_mid;
    logic [15:0] od; logic ob, oe, oo; int lat; bit rb, st, ir, spurious;
    a = 16'hABCD; b = 16'h1111; bin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, d, bout} !== 19'd0) begin
      errors++; $display("FAIL rst_mid_outputs: got rdy=%b vld=%b d=%h bout=%b want all 0", in_ready, out_valid, d, bout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    spurious = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) spurious = 1;
    end
    checks++;
    if (spurious || in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_mid_stale: got spurious_valid=%b in_ready=%b want 0 1", spurious, in_ready);
    end
    do_op(16'd5, 16'd3, 1'b0, 0, od, ob, oe, oo, lat, rb, st, ir);
    checks++;
    if (od !== 16'd2 || ob !== 1'b0 || lat !== 4) begin
      errors++; $display("FAIL rst_mid_after: got d=%h bout=%b lat=%0d want d=0002 bout=0 lat=4", od, ob, lat);
    end
  endtask

  task automatic test_random;
    logic [15:0] ra, rb16, od; logic rc, ob, oe, oo; int lat; bit rbz, st, ir; int bad;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom); rb16 = 16'($urandom); rc = 1'($urandom);
      if (i % 8 == 0) rb16 = ra;
      do_op(ra, rb16, rc, $urandom_range(0, 3), od, ob, oe, oo, lat, rbz, st, ir);
      checks++;
      if (lat !== 4 || od !== m_diff(ra, rb16, rc) || ob !== m_bout(ra, rb16, rc) || !st || !ir || rbz
`ifdef SERSUB_FLAGS_EN
          || oe !== (m_diff(ra, rb16, rc) == 16'h0) || oo !== m_ovf(ra, rb16, rc)
`endif
         ) begin
        errors++; bad++;
        $display("FAIL rand%0d: a=%h b=%h bin=%b got d=%h bout=%b lat=%0d eq=%b ovf=%b want d=%h bout=%b lat=4 eq=%b ovf=%b",
                 i, ra, rb16, rc, od, ob, lat, oe, oo, m_diff(ra, rb16, rc), m_bout(ra, rb16, rc),
                 m_diff(ra, rb16, rc) == 16'h0, m_ovf(ra, rb16, rc));
      end
      if (bad > 5) break;
    end
  endtask

  task automatic test_digit16;
    int lat, n;
    a = 16'h8000; b = 16'h0001; bin = 1'b0; iv2 = 1'b1; or2 = 1'b0;
    @(negedge clk);
    iv2 = 1'b0;
    lat = -1; n = 0;
    while (n < 16 && lat < 0) begin
      if (ov2) lat = n;
      else begin @(negedge clk); n++; end
    end
    checks++;
    if (lat !== 1) begin
      errors++; $display("FAIL d16_latency: got %0d want 1", lat);
    end
    checks++;
    if (d2 !== 16'h7FFF || bo2 !== 1'b0) begin
      errors++; $display("FAIL d16_result: got d=%h bout=%b want d=7fff bout=0", d2, bo2);
    end
`ifdef SERSUB_FLAGS_EN
    checks++;
    if (ovf2 !== 1'b1 || eq2 !== 1'b0) begin
      errors++; $display("FAIL d16_flags: got eq=%b ovf=%b want 0 1", eq2, ovf2);
    end
`endif
    or2 = 1'b1;
    @(negedge clk);
    or2 = 1'b0;
    checks++;
    if (ir2 !== 1'b1 || ov2 !== 1'b0) begin
      errors++; $display("FAIL d16_idle: got rdy=%b vld=%b want 1 0", ir2, ov2);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_digit16();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
